div: RTL and testbench
======================

# div

Multi-cycle integer divide sequencer for the EX stage of the 5-stage MIPS32 pipeline. It accepts a DIV/DIVU request from EX and runs a 32-step restoring shift-subtract datapath. It returns a 64-bit {remainder, quotient} result for the HI/LO write path. EX holds its stall request while `ready_o` is low; the block honours annulment when the pipeline flushes.

## Interface
- Parameters: none. Data width is fixed at 32 bits (`RegBus`); the result is 64 bits (`DoubleRegBus`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset (`RstEnable` = 1).
- `signed_div_i` input 1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i` input 32: dividend (rs).
- `opdata2_i` input 32: divisor (rt).
- `start_i` input 1: request level from EX; held high until the result is consumed.
- `annul_i` input 1: abort the operation in progress (pipeline flush).
- `result_o` output 64: {remainder[63:32] → HI, quotient[31:0] → LO}; registered.
- `ready_o` output 1: result valid; registered.

## Operation
- States: FREE, BYZERO, ON, END. Encoded in 2 bits; reset state is FREE.
- Reset (async, any state): state=FREE, `ready_o`=0, `result_o`=0, step counter=0, work register=0.
- FREE:
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`=0: go to BYZERO.
  - Else if `start_i`=1 and `annul_i`=0: latch absolute operands (two's-complement negate an operand when `signed_div_i`=1 and its bit 31=1). Load work register W[64:0] = {32'b0, |dividend|, 1'b0}, set counter=0, go to ON.
  - Otherwise hold; `ready_o`=0 and `result_o`=0.
- BYZERO: next state END, with W=0. Divide-by-zero result is 64'h0.
- ON, one step per cycle while counter<32:
  - Compute diff = {1'b0, W[63:32]} − {1'b0, |divisor|} (33 bits).
  - If diff[32]=1: W = {W[63:0], 1'b0}.
  - Else: W = {diff[31:0], W[31:0], 1'b1}.
  - Counter increments.
- When counter=32 in ON: quotient = W[31:0], remainder = W[64:33].
  - Signed fixup: negate the quotient if `signed_div_i` and the sign bits of the latched original operands differ. Negate the remainder if `signed_div_i` and the dividend was negative.
  - Write `result_o` = {rem, quo}, set `ready_o`=1, go to END, clear counter.
- ON with `annul_i`=1: go to FREE at the next edge. Counter=0, `ready_o` stays 0, no result is written.
- END: hold `result_o` and `ready_o`=1 while `start_i`=1. When `start_i`=0: go to FREE, `ready_o`=0, `result_o`=0.
- `annul_i` in FREE, BYZERO or END has no effect beyond the rules above. BYZERO always proceeds to END.
- Operands are sampled only on the FREE→ON edge. Input changes during ON/END are ignored.
- Arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.

## Timing
- Call the edge that samples `start_i` in FREE edge 0.
- Normal divide:
  - ON occupies edges 1..32 (32 steps).
  - The counter=32 check and result write occur at edge 33.
  - `ready_o` is first high in the cycle after edge 33, i.e. 33 cycles after request sampling.
- Divide by zero: BYZERO after edge 0, END after edge 1. `ready_o` is high after edge 2, with result 0.
- Minimum of 1 cycle in END. `ready_o` drops on the edge that samples `start_i`=0.
- Back-to-back requests: EX must drop `start_i` for at least one cycle. A new request is sampled no earlier than the edge after END→FREE.
- Reset asserted mid-ON: `ready_o`/`result_o` clear immediately (asynchronously). The first post-reset request restarts from FREE.

## Test plan
- DIVU 100 / 7 (`start_i` held high): `ready_o` rises 33 cycles after start; `result_o` = 64'h00000002_0000000E.
- DIV 0xFFFFFFF9 (−7) / 2: `result_o` = 64'hFFFFFFFF_FFFFFFFD (rem −1, quo −3). DIV 7 / 0xFFFFFFFE: `result_o` = 64'h00000001_FFFFFFFD.
- DIVU 5 / 0: `ready_o` is high 2 cycles after start; `result_o` = 0. Dropping `start_i` returns the block to FREE with `ready_o`=0.
- DIVU 0xFFFFFFFF / 1, with `annul_i` pulsed at step 10: next cycle FREE, `ready_o` never asserts. Rerun without annul: `result_o` = 64'h00000000_FFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF: `result_o` = 64'h00000000_80000000. Hold `start_i` 5 extra cycles: `ready_o` and `result_o` stay stable throughout.
- Assert `rst` asynchronously at step 20: `ready_o`/`result_o` go to 0 without waiting for a clock edge. After release, DIVU 9 / 3 gives 64'h00000000_00000003.

Source files
------------

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for the EX stage; returns {remainder, quotient}.
// Signed operands are divided as magnitudes and the signs are restored on the final step.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] w_q, w_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        neg_a, neg_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] diff;
    logic [31:0] quo, rem;

    always_comb begin
        neg_a = signed_div_i & opdata1_i[31];
        neg_b = signed_div_i & opdata2_i[31];
        abs_a = neg_a ? (32'd0 - opdata1_i) : opdata1_i;
        abs_b = neg_b ? (32'd0 - opdata2_i) : opdata2_i;
        diff  = {1'b0, w_q[63:32]} - {1'b0, divisor_q};
        quo   = neg_quo_q ? (32'd0 - w_q[31:0]) : w_q[31:0];
        rem   = neg_rem_q ? (32'd0 - w_q[64:33]) : w_q[64:33];

        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = 64'd0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = S_BYZERO;
                    end else begin
                        divisor_d = abs_b;
                        w_d       = {32'd0, abs_a, 1'b0};
                        cnt_d     = 6'd0;
                        neg_quo_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        state_d   = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                w_d     = 65'd0;
                state_d = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    cnt_d   = 6'd0;
                    state_d = S_FREE;
                end else if (cnt_q != 6'd32) begin
                    // Restore by simply not committing the subtraction when it borrows.
                    if (diff[32]) w_d = {w_q[63:0], 1'b0};
                    else          w_d = {diff[31:0], w_q[31:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem, quo};
                    ready_d  = 1'b1;
                    cnt_d    = 6'd0;
                    state_d  = S_END;
                end
            end
            S_END: begin
                if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                    state_d  = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= 6'd0;
            w_q       <= 65'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus randomized divides against a
// plain-arithmetic reference, with latency, hold, annul and async-reset checks.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] a, b;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truncating division as MIPS defines it; divide-by-zero yields 0.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint lx, ly, q, r;
        if (y == 32'd0) return 64'd0;
        if (s) begin
            lx = longint'($signed(x));
            ly = longint'($signed(y));
        end else begin
            lx = longint'({32'd0, x});
            ly = longint'({32'd0, y});
        end
        q = lx / ly;
        r = lx % ly;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input bit s, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] exp, input int hold);
        int lat;
        signed_div = s;
        a          = x;
        b          = y;
        annul      = 1'b0;
        start      = 1'b1;
        tick();
        lat = 0;
        while (!ready && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), (y == 32'd0) ? 64'd2 : 64'd33);
        check({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            a          = $urandom;
            b          = $urandom;
            signed_div = ~signed_div;
            tick();
            check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
            check({tag, "_hold_res"}, result, exp);
        end
        start = 1'b0;
        tick();
        check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        check({tag, "_drop_res"}, result, 64'd0);
        tick();
    endtask

    initial begin
        bit          seen;
        bit          s;
        logic [31:0] x, y;
        int          sel;

        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_rdy", 64'(ready), 64'd0);
        check("reset_res", result, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 1);

        // Annul part-way through; start is released with it so a missed annul would surface as ready.
        signed_div = 1'b0; a = 32'hFFFFFFFF; b = 32'd1; start = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        start = 1'b0;
        check("annul_rdy", 64'(ready), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ready) seen = 1'b1;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        run_div("annul_rerun", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0);

        run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 5);

        // Async reset mid-divide.
        signed_div = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
        tick();
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_on_rdy", 64'(ready), 64'd0);
        check("rst_on_res", result, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Async reset while a result is held in END must clear it without a clock edge.
        signed_div = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
        tick();
        for (int i = 0; i < 40 && !ready; i++) tick();
        check("end_before_rst", result, ref_div(1'b0, 32'd1000, 32'd7));
        #2 rst = 1'b1;
        #1;
        check("rst_end_rdy", 64'(ready), 64'd0);
        check("rst_end_res", result, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_div("post_rst_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);

        for (int k = 0; k < 24; k++) begin
            s   = 1'($urandom_range(0, 1));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: y = 32'd0;
                1: y = 32'd1;
                2: y = 32'hFFFFFFFF;
                3: x = 32'h80000000;
                4: y = 32'($urandom_range(1, 255));
                default: ;
            endcase
            run_div($sformatf("rand%0d", k), s, x, y, ref_div(s, x, y), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
